ecc_register_bank: RTL

Memory-mapped register bank of the ECC accelerator, directly downstream of the APB slave FSM. It consumes the FSM's `REG_ENABLE` strobe together with the APB address and write data. It holds the configuration and operand registers for the ECC core, issues a one-cycle `START` to the core, captures the core's results, and drives `PRDATA`.

---
 rtl/ecc_regs_pkg.sv | 36 +++
 rtl/ecc_access_event.sv | 26 ++
 rtl/ecc_register_bank.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ecc_regs_pkg.sv
// Shared constants for the ECC accelerator register bank: register offsets,
// core configuration encodings, strobe codes and STATUS bit positions.
package ecc_regs_pkg;

    localparam logic [2:0] ADDR_CTRL          = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN       = 3'd1;
    localparam logic [2:0] ADDR_NOISE         = 3'd2;
    localparam logic [2:0] ADDR_STATUS        = 3'd3;
    localparam logic [2:0] ADDR_DATA_OUT      = 3'd4;
    localparam logic [2:0] ADDR_NUM_OF_ERRORS = 3'd5;
    localparam logic [2:0] ADDR_CMD           = 3'd6;

    localparam logic [1:0] OP_ENCODE   = 2'b00;
    localparam logic [1:0] OP_DECODE   = 2'b01;
    localparam logic [1:0] OP_CHANNEL  = 2'b10;
    localparam logic [1:0] OP_RESERVED = 2'b11;

    localparam logic [1:0] WIDTH_8        = 2'b00;
    localparam logic [1:0] WIDTH_16       = 2'b01;
    localparam logic [1:0] WIDTH_32       = 2'b10;
    localparam logic [1:0] WIDTH_RESERVED = 2'b11;

    localparam logic [1:0] REN_NONE  = 2'b00;
    localparam logic [1:0] REN_WRITE = 2'b01;
    localparam logic [1:0] REN_READ  = 2'b10;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR  = 2;

    // CTRL layout: [1:0] OP, [3:2] WIDTH.
    function automatic logic ctrl_is_reserved(input logic [3:0] ctrl);
        return (ctrl[1:0] == OP_RESERVED) || (ctrl[3:2] == WIDTH_RESERVED);
    endfunction

endpackage

// File: rtl/ecc_access_event.sv
// Turns the APB FSM's level strobe into single-cycle write/read event pulses,
// so a strobe held across several cycles counts as one access.
module ecc_access_event
    import ecc_regs_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] reg_enable,
    output logic       wr_evt,
    output logic       rd_evt
);

    logic [1:0] prev_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_enable <= REN_NONE;
        end else begin
            prev_enable <= reg_enable;
        end
    end

    assign wr_evt = (reg_enable == REN_WRITE) && (prev_enable != REN_WRITE);
    assign rd_evt = (reg_enable == REN_READ)  && (prev_enable != REN_READ);

endmodule

// File: rtl/ecc_register_bank.sv
// Memory-mapped configuration/operand/result registers of the ECC accelerator,
// with the start/busy handshake to the core and the combinational read mux.
module ecc_register_bank
    import ecc_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            REG_ENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic [3:0]            CTRL,
    output logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] NOISE,
    output logic                  START,
    input  logic                  CORE_DONE,
    input  logic [DATA_WIDTH-1:0] CORE_DATA_OUT,
    input  logic [1:0]            CORE_NUM_OF_ERRORS
);

    logic                  wr_evt;
    logic                  rd_evt;
    logic [2:0]            addr;
    logic [3:0]            ctrl;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] noise;
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            num_errors;
    logic                  start_pulse;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  unused_addr;

    ecc_access_event u_access_event (
        .clk        (clk),
        .reset      (reset),
        .reg_enable (REG_ENABLE),
        .wr_evt     (wr_evt),
        .rd_evt     (rd_evt)
    );

    assign addr        = PADDR[4:2];
    assign unused_addr = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl        <= '0;
            data_in     <= '0;
            noise       <= '0;
            data_out    <= '0;
            num_errors  <= '0;
            start_pulse <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            start_pulse <= 1'b0;

            if (wr_evt && !busy) begin
                case (addr)
                    ADDR_CTRL:    ctrl    <= PWDATA[3:0];
                    ADDR_DATA_IN: data_in <= PWDATA;
                    ADDR_NOISE:   noise   <= PWDATA;
                    ADDR_CMD: begin
                        if (PWDATA[0]) begin
                            if (ctrl_is_reserved(ctrl)) begin
                                err <= 1'b1;
                            end else begin
                                busy        <= 1'b1;
                                start_pulse <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (rd_evt && (addr == ADDR_STATUS)) begin
                done <= 1'b0;
                err  <= 1'b0;
            end

            // NOTE: this sits after the STATUS clear on purpose; with non-blocking
            // assignments the last one wins, so a same-cycle completion keeps DONE set.
            if (CORE_DONE && busy) begin
                data_out   <= CORE_DATA_OUT;
                num_errors <= CORE_NUM_OF_ERRORS;
                busy       <= 1'b0;
                done       <= 1'b1;
            end
        end
    end

    // Read data is driven only while the read strobe is up, otherwise the bus sees 0.
    always_comb begin
        PRDATA = '0;
        if (REG_ENABLE == REN_READ) begin
            case (addr)
                ADDR_CTRL:          PRDATA = {{(DATA_WIDTH-4){1'b0}}, ctrl};
                ADDR_DATA_IN:       PRDATA = data_in;
                ADDR_NOISE:         PRDATA = noise;
                ADDR_STATUS: begin
                    PRDATA[STATUS_BUSY] = busy;
                    PRDATA[STATUS_DONE] = done;
                    PRDATA[STATUS_ERR]  = err;
                end
                ADDR_DATA_OUT:      PRDATA = data_out;
                ADDR_NUM_OF_ERRORS: PRDATA = {{(DATA_WIDTH-2){1'b0}}, num_errors};
                default:            PRDATA = '0;
            endcase
        end
    end

    assign CTRL    = ctrl;
    assign DATA_IN = data_in;
    assign NOISE   = noise;
    assign START   = start_pulse;

endmodule
